// File: rtl/addr_scan_seq_if.sv
// Bus bundle between the scan sequencer and its controller.
// The slave side is the sequencer; the master side drives scan controls.
interface addr_scan_seq_if #(
  parameter int DWELL_W = 8
);
  logic               i_enable;
  logic [7:0]         i_mask;
  logic [DWELL_W-1:0] i_dwell;
  logic               i_hold;
  logic [2:0]         o_addr;
  logic               o_valid;
  logic               o_wrap;
  logic [7:0]         o_frame_cnt;

  modport master (
    output i_enable, i_mask, i_dwell, i_hold,
    input  o_addr, o_valid, o_wrap, o_frame_cnt
  );

  modport slave (
    input  i_enable, i_mask, i_dwell, i_hold,
    output o_addr, o_valid, o_wrap, o_frame_cnt
  );
endinterface

// File: rtl/addr_scan_seq.sv
// Round-robin channel sequencer feeding a 3-to-8 address decoder.
// Steps through mask-enabled channels, dwelling i_dwell+1 cycles on each.
//
//   state   | meaning
//   S_IDLE  | not scanning; o_valid low, o_addr holds last channel
//   S_DWELL | scanning; o_addr is live, dwell counter running
module addr_scan_seq #(
  parameter int DWELL_W = 8
) (
  input logic            i_clk,
  input logic            i_rst_n,
  addr_scan_seq_if.slave bus
);

  typedef enum logic {S_IDLE, S_DWELL} state_t;

  state_t             r_state;
  logic [2:0]         r_addr;
  logic               r_valid;
  logic               r_wrap;
  logic [7:0]         r_frame_cnt;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] r_dwell_lat;

  state_t             w_state_nxt;
  logic [2:0]         w_addr_nxt;
  logic               w_wrap_nxt;
  logic [7:0]         w_frame_nxt;
  logic [DWELL_W-1:0] w_cnt_nxt;
  logic [DWELL_W-1:0] w_lat_nxt;
  logic               w_adv;
  logic [2:0]         w_low;
  logic [2:0]         w_next;
  logic               w_pass;
  logic               w_found;

  // Circular search above r_addr; a carry into bit 3 means the frame wrapped
  // (including the single-channel case where the search lands on itself).
  always_comb begin
    logic [3:0] v_sum;
    v_sum   = '0;
    w_low   = '0;
    w_next  = r_addr;
    w_pass  = 1'b0;
    w_found = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (bus.i_mask[k]) w_low = 3'(k);
    end
    for (int k = 1; k <= 8; k++) begin
      v_sum = {1'b0, r_addr} + 4'(k);
      if (!w_found && bus.i_mask[v_sum[2:0]]) begin
        w_found = 1'b1;
        w_next  = v_sum[2:0];
        w_pass  = v_sum[3];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_lat_nxt   = r_dwell_lat;
    w_frame_nxt = r_frame_cnt;
    w_wrap_nxt  = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_enable && (bus.i_mask != 8'd0)) begin
          w_state_nxt = S_DWELL;
          w_addr_nxt  = w_low;
          w_cnt_nxt   = '0;
          w_lat_nxt   = bus.i_dwell;
        end
      end
      S_DWELL: begin
        if (!bus.i_enable || (bus.i_mask == 8'd0)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (!bus.i_mask[r_addr]) begin
          w_adv = 1'b1;
        end else if (bus.i_hold) begin
          w_cnt_nxt = r_cnt;
        end else if (r_cnt == r_dwell_lat) begin
          w_adv = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + DWELL_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_adv) begin
      w_addr_nxt = w_next;
      w_cnt_nxt  = '0;
      w_lat_nxt  = bus.i_dwell;
      if (w_pass) begin
        w_wrap_nxt  = 1'b1;
        w_frame_nxt = r_frame_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_valid     <= 1'b0;
      r_wrap      <= 1'b0;
      r_frame_cnt <= '0;
      r_cnt       <= '0;
      r_dwell_lat <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_valid     <= (w_state_nxt == S_DWELL);
      r_wrap      <= w_wrap_nxt;
      r_frame_cnt <= w_frame_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dwell_lat <= w_lat_nxt;
    end
  end

  assign bus.o_addr      = r_addr;
  assign bus.o_valid     = r_valid;
  assign bus.o_wrap      = r_wrap;
  assign bus.o_frame_cnt = r_frame_cnt;

endmodule
